ram_rr_scheduler: RTL and testbench



---
 rtl/ram_rr_scheduler_pkg.sv | 21 ++
 rtl/ram_rr_scheduler_if.sv | 24 ++
 rtl/ram_rr_scheduler_rr_pick.sv | 31 +++
 rtl/ram_rr_scheduler.sv | 166 ++++++++++++++++
 tb/tb_ram_rr_scheduler.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_rr_scheduler_pkg.sv
// State encoding and index helpers shared by the RAM round-robin scheduler and its picker.
package ram_sched_pkg;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Index width for n clients, never below one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/ram_rr_scheduler_if.sv
// Client-side request/ack/read-return bundle of the RAM round-robin scheduler.
interface ram_rr_scheduler_if #(
    parameter int unsigned G_ADDR_WIDTH  = 4,
    parameter int unsigned G_DATA_WIDTH  = 8,
    parameter int unsigned G_NUM_CLIENTS = 4
);
    logic [G_NUM_CLIENTS-1:0]              req;
    logic [G_NUM_CLIENTS-1:0]              rd_not_write;
    logic [G_NUM_CLIENTS*G_ADDR_WIDTH-1:0] addr;
    logic [G_NUM_CLIENTS*G_DATA_WIDTH-1:0] wrdata;
    logic [G_NUM_CLIENTS-1:0]              ack;
    logic [G_NUM_CLIENTS-1:0]              rddata_valid_c;
    logic [G_DATA_WIDTH-1:0]               rddata_c;

    modport master (
        output req, rd_not_write, addr, wrdata,
        input  ack, rddata_valid_c, rddata_c
    );

    modport slave (
        input  req, rd_not_write, addr, wrdata,
        output ack, rddata_valid_c, rddata_c
    );
endinterface

// File: rtl/ram_rr_scheduler_rr_pick.sv
// Combinational masked round-robin picker: first eligible request at or above the pointer, modulo N.
module rr_pick
    import ram_sched_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = idx_width(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [N-1:0]  mask_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] win_idx_c_o,
    output logic          win_vld_c_o
);
    logic [N-1:0]  eligible;
    logic [IW-1:0] cand;

    assign eligible = req_i & ~mask_i;

    always_comb begin
        win_idx_c_o = '0;
        win_vld_c_o = 1'b0;
        cand        = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = IW'((32'(ptr_i) + k) % N);
            if (!win_vld_c_o && eligible[cand]) begin
                win_idx_c_o = cand;
                win_vld_c_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/ram_rr_scheduler.sv
// Round-robin scheduler sharing one RAM read/write port pair among N clients.
// Define ARB_RAM_INIT_EN to zero-fill the RAM after reset before requests are accepted.
module ram_rr_scheduler
    import ram_sched_pkg::*;
#(
    parameter int unsigned G_ADDR_WIDTH  = 4,
    parameter int unsigned G_DATA_WIDTH  = 8,
    parameter int unsigned G_NUM_CLIENTS = 4,
    parameter int unsigned G_RD_LATENCY  = 1
) (
    input  logic                    clock_i,
    input  logic                    rst_i,
    output logic                    rst_done_o,
    ram_rr_scheduler_if.slave       cli_if,
    output logic                    rd_en_o,
    output logic                    wr_en_o,
    output logic [G_ADDR_WIDTH-1:0] rd_addr_o,
    output logic [G_ADDR_WIDTH-1:0] wr_addr_o,
    output logic [G_DATA_WIDTH-1:0] wr_data_o,
    input  logic [G_DATA_WIDTH-1:0] rd_data_i
);
    localparam int unsigned AW  = G_ADDR_WIDTH;
    localparam int unsigned DW  = G_DATA_WIDTH;
    localparam int unsigned N   = G_NUM_CLIENTS;
    localparam int unsigned LAT = G_RD_LATENCY;
    localparam int unsigned IW  = idx_width(N);

    logic [0:0]    state_q,   state_d;
    logic [IW-1:0] ptr_q,     ptr_d;
    logic [N-1:0]  ack_q,     ack_d;
    logic          rd_en_q,   rd_en_d;
    logic          wr_en_q,   wr_en_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0] wr_data_q, wr_data_d;
    logic [IW-1:0] rd_idx_q,  rd_idx_d;
`ifdef ARB_RAM_INIT_EN
    logic [AW:0]   init_cnt_q, init_cnt_d;
`endif

    logic          tag_vld_q [LAT];
    logic [IW-1:0] tag_idx_q [LAT];

    logic [AW-1:0] cl_addr  [N];
    logic [DW-1:0] cl_wdata [N];
    logic [IW-1:0] win_idx;
    logic          win_vld;

    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign cl_addr[g]  = cli_if.addr[g*AW +: AW];
        assign cl_wdata[g] = cli_if.wrdata[g*DW +: DW];
    end

    // The client acked this cycle is masked so its still-high request is not re-granted.
    rr_pick #(.N(N), .IW(IW)) u_pick (
        .req_i       (cli_if.req),
        .mask_i      (ack_q),
        .ptr_i       (ptr_q),
        .win_idx_c_o (win_idx),
        .win_vld_c_o (win_vld)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        ack_d     = '0;
        rd_en_d   = 1'b0;
        wr_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        rd_idx_d  = rd_idx_q;
`ifdef ARB_RAM_INIT_EN
        init_cnt_d = init_cnt_q;
`endif
        case (state_q)
            ST_INIT: begin
`ifdef ARB_RAM_INIT_EN
                // Counter MSB set means every address has been written.
                if (init_cnt_q[AW]) begin
                    state_d = ST_RUN;
                end else begin
                    wr_en_d    = 1'b1;
                    wr_addr_d  = init_cnt_q[AW-1:0];
                    wr_data_d  = '0;
                    init_cnt_d = init_cnt_q + (AW+1)'(1);
                end
`else
                state_d = ST_RUN;
`endif
            end
            ST_RUN: begin
                if (win_vld) begin
                    ack_d = N'(1) << win_idx;
                    ptr_d = IW'(rr_next(32'(win_idx), N));
                    if (cli_if.rd_not_write[win_idx]) begin
                        rd_en_d   = 1'b1;
                        rd_addr_d = cl_addr[win_idx];
                        rd_idx_d  = win_idx;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = cl_addr[win_idx];
                        wr_data_d = cl_wdata[win_idx];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (rst_i) begin
            state_q   <= ST_INIT;
            ptr_q     <= '0;
            ack_q     <= '0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_idx_q  <= '0;
`ifdef ARB_RAM_INIT_EN
            init_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            ack_q     <= ack_d;
            rd_en_q   <= rd_en_d;
            wr_en_q   <= wr_en_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rd_idx_q  <= rd_idx_d;
`ifdef ARB_RAM_INIT_EN
            init_cnt_q <= init_cnt_d;
`endif
        end
    end

    // Tag enters one cycle after RD_EN so it emerges exactly when RD_DATA is valid.
    always_ff @(posedge clock_i) begin
        if (rst_i) begin
            for (int unsigned k = 0; k < LAT; k++) begin
                tag_vld_q[k] <= 1'b0;
                tag_idx_q[k] <= '0;
            end
        end else begin
            tag_vld_q[0] <= rd_en_q;
            tag_idx_q[0] <= rd_idx_q;
            for (int unsigned k = 1; k < LAT; k++) begin
                tag_vld_q[k] <= tag_vld_q[k-1];
                tag_idx_q[k] <= tag_idx_q[k-1];
            end
        end
    end

    assign rst_done_o            = (state_q == ST_RUN);
    assign rd_en_o               = rd_en_q;
    assign wr_en_o               = wr_en_q;
    assign rd_addr_o             = rd_addr_q;
    assign wr_addr_o             = wr_addr_q;
    assign wr_data_o             = wr_data_q;
    assign cli_if.ack            = ack_q;
    assign cli_if.rddata_valid_c = tag_vld_q[LAT-1] ? (N'(1) << tag_idx_q[LAT-1]) : '0;
    assign cli_if.rddata_c       = rd_data_i;
endmodule

// File: tb/tb_ram_rr_scheduler.sv
// Directed bench for ram_rr_scheduler: one instance at read latency 1, one at read latency 3.
module tb_ram_rr_scheduler;
    localparam int unsigned AW = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned N  = 4;
`ifdef ARB_RAM_INIT_EN
    localparam bit PRELOAD = 1'b0;
`else
    localparam bit PRELOAD = 1'b1;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ram_rr_scheduler_if #(.G_ADDR_WIDTH(AW), .G_DATA_WIDTH(DW), .G_NUM_CLIENTS(N)) ifc1 ();
    ram_rr_scheduler_if #(.G_ADDR_WIDTH(AW), .G_DATA_WIDTH(DW), .G_NUM_CLIENTS(N)) ifc3 ();

    assign ifc3.req          = ifc1.req;
    assign ifc3.rd_not_write = ifc1.rd_not_write;
    assign ifc3.addr         = ifc1.addr;
    assign ifc3.wrdata       = ifc1.wrdata;

    logic          rd_en1, wr_en1, rst_done1, rd_en3, wr_en3, rst_done3;
    logic [AW-1:0] rd_addr1, wr_addr1, rd_addr3, wr_addr3;
    logic [DW-1:0] wr_data1, wr_data3, rd_data1, rd_data3;

    ram_rr_scheduler #(.G_ADDR_WIDTH(AW), .G_DATA_WIDTH(DW), .G_NUM_CLIENTS(N), .G_RD_LATENCY(1)) u_dut1 (
        .clock_i(clk), .rst_i(rst), .rst_done_o(rst_done1), .cli_if(ifc1),
        .rd_en_o(rd_en1), .wr_en_o(wr_en1), .rd_addr_o(rd_addr1), .wr_addr_o(wr_addr1),
        .wr_data_o(wr_data1), .rd_data_i(rd_data1)
    );

    ram_rr_scheduler #(.G_ADDR_WIDTH(AW), .G_DATA_WIDTH(DW), .G_NUM_CLIENTS(N), .G_RD_LATENCY(3)) u_dut3 (
        .clock_i(clk), .rst_i(rst), .rst_done_o(rst_done3), .cli_if(ifc3),
        .rd_en_o(rd_en3), .wr_en_o(wr_en3), .rd_addr_o(rd_addr3), .wr_addr_o(wr_addr3),
        .wr_data_o(wr_data3), .rd_data_i(rd_data3)
    );

    function automatic logic [DW-1:0] pre(input logic [AW-1:0] a);
        return PRELOAD ? (8'h10 + DW'(a)) : '0;
    endfunction

    // RAM model: writes come from the latency-1 instance; two read ports of latency 1 and 3.
    logic [DW-1:0] mem [1<<AW];
    logic [DW-1:0] d1, d2;
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= pre(AW'(i));
        end else if (wr_en1) begin
            mem[wr_addr1] <= wr_data1;
        end
        if (rd_en1) rd_data1 <= mem[rd_addr1];
        d1       <= mem[rd_addr3];
        d2       <= d1;
        rd_data3 <= d2;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cli(input int i, input logic rnw, input logic [AW-1:0] a, input logic [DW-1:0] d);
        ifc1.rd_not_write[i]   = rnw;
        ifc1.addr[i*AW +: AW]  = a;
        ifc1.wrdata[i*DW +: DW] = d;
    endtask

    initial begin
        logic done;
        rst               = 1'b1;
        ifc1.req          = '0;
        ifc1.rd_not_write = '0;
        ifc1.addr         = '0;
        ifc1.wrdata       = '0;
        repeat (3) tick();

        chk("rst_rd_en", rd_en1, 0);
        chk("rst_wr_en", wr_en1, 0);
        chk("rst_ack", ifc1.ack, 0);
        chk("rst_valid", ifc1.rddata_valid_c, 0);
        chk("rst_done_low", rst_done1, 0);
        chk("rst_rd_addr", rd_addr1, 0);
        chk("rst_wr_addr", wr_addr1, 0);
        chk("rst_wr_data", wr_data1, 0);
        chk("rst_done_low3", rst_done3, 0);

        rst = 1'b0;
`ifdef ARB_RAM_INIT_EN
        for (int k = 0; k < 16; k++) begin
            tick();
            chk("init_wr_en", wr_en1, 1);
            chk("init_wr_addr", wr_addr1, k);
            chk("init_wr_data", wr_data1, 0);
            chk("init_ack", ifc1.ack, 0);
            chk("init_done_low", rst_done1, 0);
        end
`endif
        tick();
        chk("rst_done", rst_done1, 1);
        chk("rst_done3", rst_done3, 1);
        chk("idle_wr_en", wr_en1, 0);

        // All four clients read continuously: grants rotate 0,1,2,3,0.
        for (int i = 0; i < 4; i++) set_cli(i, 1'b1, AW'(3 + 2*i), '0);
        ifc1.req = 4'hF;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rr_ack", ifc1.ack, 32'd1 << (k % 4));
            chk("rr_rd_en", rd_en1, 1);
            chk("rr_wr_en", wr_en1, 0);
            chk("rr_rd_addr", rd_addr1, 3 + 2*(k % 4));
            if (k == 0) begin
                chk("rr_valid_first", ifc1.rddata_valid_c, 0);
            end else begin
                chk("rr_valid", ifc1.rddata_valid_c, 32'd1 << ((k - 1) % 4));
                chk("rr_data", ifc1.rddata_c, pre(AW'(3 + 2*((k - 1) % 4))));
            end
        end
        ifc1.req = '0;
        tick();
        chk("idle_ack", ifc1.ack, 0);
        chk("idle_rd_en", rd_en1, 0);
        chk("idle_rd_addr_hold", rd_addr1, 3);
        chk("rr_valid_last", ifc1.rddata_valid_c, 1);
        chk("rr_data_last", ifc1.rddata_c, pre(3));
        tick();
        chk("idle_valid", ifc1.rddata_valid_c, 0);

        // Pointer is 1: client 2 write wins before client 0 read of the same address.
        set_cli(0, 1'b1, 6, '0);
        set_cli(2, 1'b0, 6, 8'hA5);
        ifc1.req = 4'b0101;
        tick();
        chk("wr_first_en", wr_en1, 1);
        chk("wr_first_addr", wr_addr1, 6);
        chk("wr_first_data", wr_data1, 8'hA5);
        chk("wr_first_ack", ifc1.ack, 4'b0100);
        chk("wr_first_rd_en", rd_en1, 0);
        ifc1.req[2] = 1'b0;
        tick();
        chk("rd_after_en", rd_en1, 1);
        chk("rd_after_addr", rd_addr1, 6);
        chk("rd_after_ack", ifc1.ack, 4'b0001);
        chk("rd_after_wr_en", wr_en1, 0);
        ifc1.req[0] = 1'b0;
        tick();
        chk("raw_valid", ifc1.rddata_valid_c, 4'b0001);
        chk("raw_data", ifc1.rddata_c, 8'hA5);
        chk("raw_ack", ifc1.ack, 0);
        chk("raw_wr_addr_hold", wr_addr1, 6);

        // Lone client 1 holding its request: grants every second cycle.
        set_cli(1, 1'b1, 5, '0);
        ifc1.req = 4'b0010;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("solo_ack", ifc1.ack, (k % 2 == 0) ? 4'b0010 : 4'b0000);
            chk("solo_rd_en", rd_en1, (k % 2 == 0) ? 1 : 0);
            if (k > 0) chk("solo_valid", ifc1.rddata_valid_c, (k % 2 == 1) ? 4'b0010 : 4'b0000);
        end
        ifc1.req = '0;
        tick();
        chk("solo_end_ack", ifc1.ack, 0);

        // Latency 3: reads from clients 3,0,2 back to back (pointer is 2).
        set_cli(3, 1'b1, 9, '0);
        set_cli(0, 1'b1, 6, '0);
        set_cli(2, 1'b1, 7, '0);
        ifc1.req = 4'b1000;
        tick();
        chk("l3_ack3", ifc3.ack, 4'b1000);
        ifc1.req = 4'b0101;
        tick();
        chk("l3_ack0", ifc3.ack, 4'b0001);
        chk("l3_v_early", ifc3.rddata_valid_c, 0);
        ifc1.req = 4'b0100;
        tick();
        chk("l3_ack2", ifc3.ack, 4'b0100);
        chk("l3_v_early2", ifc3.rddata_valid_c, 0);
        ifc1.req = '0;
        tick();
        chk("l3_valid3", ifc3.rddata_valid_c, 4'b1000);
        chk("l3_data3", ifc3.rddata_c, pre(9));
        tick();
        chk("l3_valid0", ifc3.rddata_valid_c, 4'b0001);
        chk("l3_data0", ifc3.rddata_c, 8'hA5);
        tick();
        chk("l3_valid2", ifc3.rddata_valid_c, 4'b0100);
        chk("l3_data2", ifc3.rddata_c, pre(7));
        tick();
        chk("l3_valid_end", ifc3.rddata_valid_c, 0);

        // Reset one cycle after a read issue drops the in-flight read.
        set_cli(1, 1'b1, 5, '0);
        ifc1.req = 4'b0010;
        tick();
        chk("mid_issue", rd_en1, 1);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("mid_rd_en", rd_en1, 0);
            chk("mid_ack", ifc1.ack, 0);
            chk("mid_valid1", ifc1.rddata_valid_c, 0);
            chk("mid_valid3", ifc3.rddata_valid_c, 0);
            chk("mid_rst_done", rst_done1, 0);
            chk("mid_rd_addr", rd_addr1, 0);
        end
        // Pointer reset to 0 makes client 1 win over client 2.
        ifc1.req = 4'b0110;
        rst = 1'b0;
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            tick();
            done = rst_done1;
        end
        chk("re_done", rst_done1, 1);
        chk("re_ack_idle", ifc1.ack, 0);
        tick();
        chk("re_ptr_ack", ifc1.ack, 4'b0010);
        chk("re_ptr_addr", rd_addr1, 5);
        ifc1.req = '0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
